avm_cmd_master: RTL

Avalon-MM master that turns a simple command/response interface into Avalon-MM read/write transfers toward slaves such as the UART register block. Honors avs-side waitrequest with zero read latency: readdata is sampled on the edge where waitrequest is low. Supports multi-beat commands with word-address increment, issued back-to-back. Sits between a sequencer, CPU-less test harness or bridge and one Avalon-MM slave port.

---
 rtl/avm_cmd_master.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/avm_cmd_master.sv
// Avalon-MM master: converts single/multi-beat commands into zero-latency Avalon-MM transfers.
// Optional waitrequest stall timeout is enabled by defining AVM_TIMEOUT_EN.
module avm_cmd_master #(
    parameter int ADDR_W         = 3,
    parameter int LEN_W          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [31:0]       cmd_writedata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_readdata,
    output logic              rsp_last,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] avm_m0_address,
    output logic              avm_m0_read,
    output logic              avm_m0_write,
    output logic [31:0]       avm_m0_writedata,
    input  logic              avm_m0_waitrequest,
    input  logic [31:0]       avm_m0_readdata
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state, state_nx;
    logic [LEN_W-1:0]  beats_left, beats_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              rd_nx, wr_nx, ready_nx;
    logic [31:0]       wdata_nx, rsp_data_nx;
    logic              rsp_valid_nx, rsp_last_nx, rsp_error_nx;

`ifdef AVM_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [TO_W-1:0] to_cnt, to_cnt_nx;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            beats_left       <= '0;
            cmd_ready        <= 1'b1;
            avm_m0_address   <= '0;
            avm_m0_read      <= 1'b0;
            avm_m0_write     <= 1'b0;
            avm_m0_writedata <= '0;
            rsp_valid        <= 1'b0;
            rsp_last         <= 1'b0;
            rsp_error        <= 1'b0;
            rsp_readdata     <= '0;
`ifdef AVM_TIMEOUT_EN
            to_cnt           <= '0;
`endif
        end else begin
            state            <= state_nx;
            beats_left       <= beats_nx;
            cmd_ready        <= ready_nx;
            avm_m0_address   <= addr_nx;
            avm_m0_read      <= rd_nx;
            avm_m0_write     <= wr_nx;
            avm_m0_writedata <= wdata_nx;
            rsp_valid        <= rsp_valid_nx;
            rsp_last         <= rsp_last_nx;
            rsp_error        <= rsp_error_nx;
            rsp_readdata     <= rsp_data_nx;
`ifdef AVM_TIMEOUT_EN
            to_cnt           <= to_cnt_nx;
`endif
        end
    end

    // The strobe is asserted for the whole ACCESS state, so a low waitrequest there completes a beat.
    always_comb begin
        state_nx     = state;
        beats_nx     = beats_left;
        ready_nx     = cmd_ready;
        addr_nx      = avm_m0_address;
        rd_nx        = avm_m0_read;
        wr_nx        = avm_m0_write;
        wdata_nx     = avm_m0_writedata;
        rsp_valid_nx = 1'b0;
        rsp_last_nx  = 1'b0;
        rsp_error_nx = 1'b0;
        rsp_data_nx  = rsp_readdata;
`ifdef AVM_TIMEOUT_EN
        to_cnt_nx    = to_cnt;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nx = ACCESS;
                    beats_nx = cmd_len;
                    ready_nx = 1'b0;
                    addr_nx  = cmd_address;
                    rd_nx    = !cmd_write;
                    wr_nx    = cmd_write;
                    wdata_nx = cmd_writedata;
`ifdef AVM_TIMEOUT_EN
                    to_cnt_nx = '0;
`endif
                end
            end
            ACCESS: begin
                if (!avm_m0_waitrequest) begin
                    rsp_valid_nx = 1'b1;
                    rsp_data_nx  = avm_m0_write ? 32'h0 : avm_m0_readdata;
                    rsp_last_nx  = (beats_left == '0);
`ifdef AVM_TIMEOUT_EN
                    to_cnt_nx    = '0;
`endif
                    if (beats_left != '0) begin
                        addr_nx  = avm_m0_address + ADDR_W'(1);
                        beats_nx = beats_left - LEN_W'(1);
                    end else begin
                        rd_nx    = 1'b0;
                        wr_nx    = 1'b0;
                        ready_nx = 1'b1;
                        state_nx = IDLE;
                    end
                end
`ifdef AVM_TIMEOUT_EN
                // This stall edge is the TIMEOUT_CYCLES-th one: abort and drop the remaining beats.
                else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_nx = 1'b1;
                    rsp_error_nx = 1'b1;
                    rsp_last_nx  = 1'b1;
                    rsp_data_nx  = 32'h0;
                    rd_nx        = 1'b0;
                    wr_nx        = 1'b0;
                    ready_nx     = 1'b1;
                    beats_nx     = '0;
                    to_cnt_nx    = '0;
                    state_nx     = IDLE;
                end else begin
                    to_cnt_nx = to_cnt + TO_W'(1);
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
